uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver with oversampled, majority-voted bit recovery and configurable frame format (data bits, parity, stop bits).
Delivers each received character through a one-entry holding register with a valid/ready handshake.
Flags parity, framing, overrun and break conditions per character.
Sits between the pad-side rx line and the UART register/FIFO layer; shares sys_clk with the baud generator, which supplies the oversample strobe.

Parameters:
DATA_BITS, 8, character width; legal 5..9
OVERSAMPLE, 16, os_tick strobes per bit; legal 8 or 16
PARITY_EN, 0, 1 = parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
os_tick  in  1  single-sys_clk-cycle strobe at OVERSAMPLE x baud rate
rx_in  in  1  asynchronous serial input; idle high
rx_ready  in  1  consumer accepts the character when rx_valid & rx_ready
rx_data  out  DATA_BITS  received character, LSB = first data bit
rx_valid  out  1  holding register occupied
parity_err  out  1  parity mismatch; qualifies rx_data, valid with rx_valid
frame_err  out  1  a stop bit sampled 0; qualifies rx_data, valid with rx_valid
break_det  out  1  break received; qualifies rx_data, valid with rx_valid
overrun  out  1  one-cycle pulse: a character completed while the holding register was full
rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, all flags=0, rx_busy=0, state=IDLE. Synchroniser flops reset to 1.
- Reset mid-frame aborts the frame; no partial character is delivered.
- Input path: rx_in passes through a 2-flop synchroniser. All logic below uses the synchronised value rx_s.
- Tick counter: tick_cnt, width log2(OVERSAMPLE). It advances only on os_tick; all state logic is gated by os_tick.
- Sampling: at tick_cnt = H-1, H and H+1 (H = OVERSAMPLE/2), take samples s0, s1, s2. Bit value = majority(s0, s1, s2).
- The bit ends at tick_cnt = OVERSAMPLE-1, when tick_cnt wraps to 0.
- States and transitions:
  - IDLE: on os_tick with rx_s=0, clear tick_cnt and go to START.
  - START: at bit end, if the majority is 1 (false start) go back to IDLE with no output; else go to DATA.
  - DATA: shift the majority value in LSB-first. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compute the expected bit = XOR of the data, inverted if PARITY_ODD. Mismatch sets the internal perr. Then go to STOP.
  - STOP: check STOP_BITS bits; any 0 sets the internal ferr.
    - If the frame is a break (all data=0, parity bit=0 when enabled, first stop bit=0), commit and go to BRK_WAIT.
    - Else commit and go to IDLE.
  - Commit happens at the end of the first stop bit's sample window (tick_cnt = H+1). The second stop bit is still checked but does not delay commit; ferr from it is ORed into the committed frame_err in the following cycle.
  - BRK_WAIT: stay until rx_s=1 is seen on an os_tick, then go to IDLE. This prevents a spurious start during break.
- Commit:
  - If rx_valid=0: load rx_data, parity_err, frame_err, break_det; set rx_valid.
  - If rx_valid=1 (and not being accepted in the same cycle): drop the new character, keep the old contents, pulse overrun for 1 cycle.
- Simultaneous accept and commit (rx_valid & rx_ready in the commit cycle): the load wins, rx_valid stays 1, no overrun.
- Handshake:
  - rx_valid & rx_ready with no commit clears rx_valid in the next cycle.
  - rx_data and the flags hold stable while rx_valid=1.
- Latency: rx_valid rises 1 sys_clk after the commit os_tick, i.e. about 0.5 bit-time after the first stop bit starts.
- Glitch rejection: a single-sample low pulse on rx_s fails START validation and produces no output.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}
  - function parity_calc(data, odd)
  - legal-value localparams for DATA_BITS and OVERSAMPLE
- Sub-module uart_rx_sampler: 2-flop synchroniser, tick_cnt, 3-sample majority vote. Outputs bit_val and bit_done strobes. It can be reused by a future autobaud block.
- The rest (FSM, shift register, holding register) stays in uart_rx_param.

Test Plan:
- Default params, send 0x55 then 0xA5 (8N1) -> rx_data=0x55 then 0xA5, each rx_valid with all flags 0; rx_busy low between frames.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2; send 0x41 with a corrupted parity bit -> rx_data=0x41, parity_err=1; the correct-parity repeat gives parity_err=0.
- Stop bit forced 0 on 0x3C -> rx_data=0x3C, frame_err=1. A 0.3-bit low glitch on an idle line -> no rx_valid, rx_busy returns 0.
- Hold rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse. With rx_ready=1 pulsed exactly at the 0x22 commit cycle -> rx_data=0x22, no overrun.
- Line low for 2 frame times -> one character rx_data=0x00 with break_det=1 and frame_err=1; no further rx_valid until the line returns high; next frame 0x7E is received cleanly.
- Assert rst during bit 4 of 0xF0 -> all outputs 0 within 1 cycle; the next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   // Receiver frame states; BRK_WAIT parks the FSM until the line recovers.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_t;

   // Legal parameter ranges for the receiver.
   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 9;
   localparam int OVERSAMPLE_LO = 8;
   localparam int OVERSAMPLE_HI = 16;

   // Expected parity bit: XOR of the data, inverted for odd parity.
   // Data narrower than DATA_BITS_MAX is zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_calc(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit recovery front end: 2-flop synchroniser, oversample tick counter and
// 3-sample majority vote around the bit centre. Kept free of frame knowledge
// so it can be reused by an autobaud block.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic os_tick,
   input  logic rx_in,
   input  logic cnt_clr,     // restart bit timing (start edge seen)
   output logic rx_s,        // synchronised line
   output logic samp_val,    // majority of the window, valid with samp_done
   output logic samp_done,   // strobe: last sample of the window taken
   output logic bit_val,     // majority held from samp_done until the next window
   output logic bit_done     // strobe: bit period ends, counter wraps
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int H  = OVERSAMPLE / 2;

   logic          rx_m;
   logic [CW-1:0] tick_cnt;
   logic          s0, s1;

   // Third sample is the live synchronised value, so the vote is ready on the last window tick.
   assign samp_val  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   assign samp_done = os_tick && (tick_cnt == CW'(H + 1));
   assign bit_done  = os_tick && (tick_cnt == CW'(OVERSAMPLE - 1));

   // Two-stage synchroniser; resets to the idle (high) line level.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
      end
   end

   // Tick counter: advances per os_tick, wraps naturally at OVERSAMPLE (power of two).
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (os_tick) begin
         tick_cnt <= cnt_clr ? '0 : tick_cnt + CW'(1);
      end
   end

   // Capture the samples at H-1 and H, latch the vote at H+1.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         s0      <= 1'b1;
         s1      <= 1'b1;
         bit_val <= 1'b1;
      end else if (os_tick) begin
         if (tick_cnt == CW'(H - 1)) s0 <= rx_s;
         if (tick_cnt == CW'(H))     s1 <= rx_s;
         if (tick_cnt == CW'(H + 1)) bit_val <= samp_val;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shift register and a one-entry
// holding register with valid/ready handoff and per-character error flags.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 os_tick,
   input  logic                 rx_in,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int BCW = $clog2(DATA_BITS);

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic                 perr;
      logic                 ferr;
      logic                 brk;
   } rx_char_t;

   rx_state_t            state;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 perr;
   logic                 stop_idx;   // 0 = first stop bit, 1 = second
   logic                 ferr2_p;    // late frame error from the second stop bit
   logic                 late_ok;    // holding register still owns the last committed frame

   logic                 rx_s, samp_val, samp_done, bit_val, bit_done;
   logic                 cnt_clr, commit, brk_now;
   rx_char_t             hold_q, new_char;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .os_tick   (os_tick),
      .rx_in     (rx_in),
      .cnt_clr   (cnt_clr),
      .rx_s      (rx_s),
      .samp_val  (samp_val),
      .samp_done (samp_done),
      .bit_val   (bit_val),
      .bit_done  (bit_done)
   );

   // Start edge realigns bit timing to the falling edge.
   assign cnt_clr = os_tick && (state == IDLE) && !rx_s;

   // Commit at the end of the first stop bit's sample window.
   assign commit  = samp_done && (state == STOP) && !stop_idx;

   // Break: all data zero, parity bit zero (always zero when parity is off), first stop zero.
   assign brk_now = (shreg == '0) && !par_bit && !samp_val;

   assign new_char = '{data: shreg, perr: perr, ferr: !samp_val, brk: brk_now};

   assign rx_data    = hold_q.data;
   assign parity_err = hold_q.perr;
   assign frame_err  = hold_q.ferr;
   assign break_det  = hold_q.brk;
   assign rx_busy    = (state != IDLE);

   // Frame FSM: every transition is qualified by os_tick.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         perr     <= 1'b0;
         stop_idx <= 1'b0;
         ferr2_p  <= 1'b0;
      end else begin
         ferr2_p <= 1'b0;
         if (os_tick) begin
            unique case (state)
               IDLE: if (!rx_s) begin
                  state   <= START;
                  par_bit <= 1'b0;
                  perr    <= 1'b0;
               end
               START: if (bit_done) begin
                  if (bit_val) begin
                     state <= IDLE;        // false start / glitch
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: if (bit_done) begin
                  shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                     state    <= (PARITY_EN != 0) ? PARITY : STOP;
                     stop_idx <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                  end
               end
               PARITY: if (bit_done) begin
                  par_bit  <= bit_val;
                  perr     <= bit_val ^ parity_calc(DATA_BITS_MAX'(shreg), 1'(PARITY_ODD));
                  state    <= STOP;
                  stop_idx <= 1'b0;
               end
               STOP: begin
                  if (samp_done) begin
                     if (!stop_idx) begin
                        if (brk_now)              state <= BRK_WAIT;
                        else if (STOP_BITS == 1)  state <= IDLE;
                     end else begin
                        ferr2_p <= !samp_val;
                        state   <= IDLE;
                     end
                  end else if (bit_done) begin
                     stop_idx <= 1'b1;
                  end
               end
               BRK_WAIT: if (rx_s) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Holding register: load on commit when free or being drained, else flag overrun.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         hold_q   <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
         late_ok  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (commit) begin
            if (!rx_valid || rx_ready) begin
               hold_q   <= new_char;
               rx_valid <= 1'b1;
               late_ok  <= 1'b1;
            end else begin
               overrun  <= 1'b1;
               late_ok  <= 1'b0;
            end
         end else begin
            if (rx_valid && rx_ready) begin
               rx_valid <= 1'b0;
               late_ok  <= 1'b0;
            end
            if (ferr2_p && late_ok) hold_q.ferr <= 1'b1;
         end
      end
   end

endmodule
